// File: rtl/mtsp_scs_sequencer.sv
// mtsp_scs_sequencer
//   Command front-end for the scratch-counter array. Accepts valid/ready
//   counter requests and drives per-element enable/op/data/carry-in for
//   SC_COUNT counter elements. A request addresses a group of 1..4 adjacent
//   elements that behave as one wide chained counter. GET/GETnINC return the
//   sampled (pre-increment) words as a response stream. SET/SET_LIMIT return
//   a single ack beat.
//
// Ports
//   CLK, nRST       clock, asynchronous active-low reset
//   REQ_*           request stream (header beat: OP/INDEX/LEN/TAG/DATA;
//                   further SET beats: DATA only)
//   SC_nEN/SC_OP    per-element enable (active low) and op, registered
//   SC_DATA_IN      shared write word, registered
//   SC_CARRY_IN     per-element carry input, combinational from SC_CARRY_OUT
//   SC_DATA_OUT     packed element counter values
//   SC_CARRY_OUT    element carry outputs
//   RSP_*           response stream (DATA/TAG/LAST/CARRY/ERR)

module mtsp_scs_sequencer #(
   parameter int unsigned SC_COUNT = 8,
   parameter int unsigned WORD_W   = 16,
   parameter int unsigned TAG_W    = 4,
   localparam int unsigned IW      = (SC_COUNT > 1) ? $clog2(SC_COUNT) : 1
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       REQ_VALID,
   output logic                       REQ_READY,
   input  logic [1:0]                 REQ_OP,
   input  logic [IW-1:0]              REQ_INDEX,
   input  logic [1:0]                 REQ_LEN,
   input  logic [TAG_W-1:0]           REQ_TAG,
   input  logic [WORD_W-1:0]          REQ_DATA,
   output logic [SC_COUNT-1:0]        SC_nEN,
   output logic [2*SC_COUNT-1:0]      SC_OP,
   output logic [WORD_W-1:0]          SC_DATA_IN,
   output logic [SC_COUNT-1:0]        SC_CARRY_IN,
   input  logic [WORD_W*SC_COUNT-1:0] SC_DATA_OUT,
   input  logic [SC_COUNT-1:0]        SC_CARRY_OUT,
   output logic                       RSP_VALID,
   input  logic                       RSP_READY,
   output logic [WORD_W-1:0]          RSP_DATA,
   output logic [TAG_W-1:0]           RSP_TAG,
   output logic                       RSP_LAST,
   output logic                       RSP_CARRY,
   output logic                       RSP_ERR
);

   localparam int NumEl = int'(SC_COUNT);
   localparam int WordW = int'(WORD_W);

   localparam logic [1:0] OpGet     = 2'd0;
   localparam logic [1:0] OpGetNInc = 2'd1;

   typedef enum logic [1:0] {StIdle, StWdata, StIssue, StResp} state_e;

   state_e            state_q;
   logic [IW-1:0]     base_q;
   logic [1:0]        len_q;
   logic [1:0]        op_q;
   logic [1:0]        wcnt_q;
   logic [1:0]        beat_q;
   logic [1:0]        rlen_q;
   logic              err_q;
   logic [WORD_W-1:0] rbuf_q [4];

   int                hdr_base;
   int                hdr_last;
   logic              hdr_err;
   int                grp_base;
   int                grp_last;
   logic              grp_carry;
   logic [WORD_W-1:0] rd_word [4];

   assign hdr_base = int'(REQ_INDEX);
   assign hdr_last = hdr_base + int'(REQ_LEN);
   assign hdr_err  = (hdr_last >= NumEl);
   assign grp_base = int'(base_q);
   assign grp_last = grp_base + int'(len_q);

   // Carry chain only exists inside the group being issued; the base element
   // never receives a carry so the chain cannot leak in from a neighbour.
   always_comb begin
      SC_CARRY_IN = '0;
      grp_carry   = 1'b0;
      if (state_q == StIssue) begin
         for (int i = 1; i < NumEl; i++) begin
            if (i > grp_base && i <= grp_last) begin
               SC_CARRY_IN[i] = SC_CARRY_OUT[i-1];
            end
         end
         for (int i = 0; i < NumEl; i++) begin
            if (i == grp_last) begin
               grp_carry = SC_CARRY_OUT[i];
            end
         end
      end
   end

   // Words of the current group as seen on SC_DATA_OUT; unused slots read 0.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_word[k] = '0;
         for (int i = 0; i < NumEl; i++) begin
            if (k <= int'(len_q) && i == grp_base + k) begin
               rd_word[k] = SC_DATA_OUT[i*WordW +: WordW];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= StIdle;
         base_q     <= '0;
         len_q      <= '0;
         op_q       <= '0;
         wcnt_q     <= '0;
         beat_q     <= '0;
         rlen_q     <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            rbuf_q[k] <= '0;
         end
         REQ_READY  <= 1'b0;
         SC_nEN     <= '1;
         SC_OP      <= '0;
         SC_DATA_IN <= '0;
         RSP_VALID  <= 1'b0;
         RSP_DATA   <= '0;
         RSP_TAG    <= '0;
         RSP_LAST   <= 1'b0;
         RSP_CARRY  <= 1'b0;
         RSP_ERR    <= 1'b0;
      end else begin
         // Element strobes last exactly one cycle unless re-armed below.
         SC_nEN <= '1;
         SC_OP  <= '0;
         unique case (state_q)
            StIdle: begin
               if (!REQ_READY) begin
                  REQ_READY <= 1'b1;
               end else if (REQ_VALID) begin
                  base_q  <= REQ_INDEX;
                  len_q   <= REQ_LEN;
                  op_q    <= REQ_OP;
                  RSP_TAG <= REQ_TAG;
                  beat_q  <= '0;
                  err_q   <= 1'b0;
                  rlen_q  <= '0;
                  if (hdr_err) begin
                     err_q     <= 1'b1;
                     REQ_READY <= 1'b0;
                     state_q   <= StResp;
                  end else if (!REQ_OP[1]) begin
                     // Upper words get OP=GET so they only move on carry-in.
                     rlen_q    <= REQ_LEN;
                     REQ_READY <= 1'b0;
                     state_q   <= StIssue;
                     for (int i = 0; i < NumEl; i++) begin
                        if (i >= hdr_base && i <= hdr_last) begin
                           SC_nEN[i]       <= 1'b0;
                           SC_OP[2*i +: 2] <= (i == hdr_base) ? REQ_OP : OpGet;
                        end
                     end
                  end else begin
                     SC_DATA_IN <= REQ_DATA;
                     wcnt_q     <= 2'd1;
                     for (int i = 0; i < NumEl; i++) begin
                        if (i == hdr_base) begin
                           SC_nEN[i]       <= 1'b0;
                           SC_OP[2*i +: 2] <= REQ_OP;
                        end
                     end
                     if (REQ_LEN == 2'd0) begin
                        REQ_READY <= 1'b0;
                        state_q   <= StResp;
                     end else begin
                        state_q <= StWdata;
                     end
                  end
               end
            end

            StWdata: begin
               if (REQ_READY && REQ_VALID) begin
                  SC_DATA_IN <= REQ_DATA;
                  for (int i = 0; i < NumEl; i++) begin
                     if (i == grp_base + int'(wcnt_q)) begin
                        SC_nEN[i]       <= 1'b0;
                        SC_OP[2*i +: 2] <= op_q;
                     end
                  end
                  if (wcnt_q == len_q) begin
                     REQ_READY <= 1'b0;
                     state_q   <= StResp;
                  end else begin
                     wcnt_q <= wcnt_q + 2'd1;
                  end
               end
            end

            StIssue: begin
               // Elements update on this edge, so SC_DATA_OUT is pre-increment.
               for (int k = 0; k < 4; k++) begin
                  rbuf_q[k] <= rd_word[k];
               end
               RSP_VALID <= 1'b1;
               RSP_DATA  <= rd_word[0];
               RSP_LAST  <= (len_q == 2'd0);
               RSP_CARRY <= grp_carry & (op_q == OpGetNInc);
               RSP_ERR   <= 1'b0;
               state_q   <= StResp;
            end

            StResp: begin
               if (!RSP_VALID) begin
                  // Single-beat ack or error response.
                  RSP_VALID <= 1'b1;
                  RSP_DATA  <= '0;
                  RSP_LAST  <= 1'b1;
                  RSP_CARRY <= 1'b0;
                  RSP_ERR   <= err_q;
               end else if (RSP_READY) begin
                  if (beat_q == rlen_q) begin
                     RSP_VALID <= 1'b0;
                     RSP_DATA  <= '0;
                     RSP_LAST  <= 1'b0;
                     RSP_CARRY <= 1'b0;
                     RSP_ERR   <= 1'b0;
                     REQ_READY <= 1'b1;
                     state_q   <= StIdle;
                  end else begin
                     beat_q   <= beat_q + 2'd1;
                     RSP_DATA <= rbuf_q[beat_q + 2'd1];
                     RSP_LAST <= ((beat_q + 2'd1) == rlen_q);
                  end
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mtsp_scs_sequencer.md
Name: mtsp_scs_sequencer

Overview:
- Command front-end for the scratch-counter array. Accepts valid/ready counter requests from the thread/instruction pipeline and drives per-element enable, op, data and carry-in for SC_COUNT counter elements.
- Groups 1..4 adjacent elements into one wide chained counter and returns the sampled counter words as a response stream.
- Sits directly upstream of the counter elements and consumes their DATA_OUT/CARRY_OUT.

Parameters:
SC_COUNT, 8, number of counter elements driven (power of two, 2..32)
WORD_W, 16, counter element word width
TAG_W, 4, request/response tag width

Ports:
CLK  in  1  main clock
nRST  in  1  asynchronous active-low reset
REQ_VALID  in  1  request beat valid
REQ_READY  out  1  request beat accepted when VALID&READY
REQ_OP  in  2  0=GET, 1=GETnINC, 2=SET, 3=SET_LIMIT (header beat only)
REQ_INDEX  in  log2(SC_COUNT)  base element of group (header beat only)
REQ_LEN  in  2  group length minus 1, i.e. 1..4 words (header beat only)
REQ_TAG  in  TAG_W  returned on the response (header beat only)
REQ_DATA  in  WORD_W  write word (SET/SET_LIMIT beats, LS word first)
SC_nEN  out  SC_COUNT  per-element enable, active low
SC_OP  out  2*SC_COUNT  per-element op, same encoding as REQ_OP
SC_DATA_IN  out  WORD_W  shared write data to elements
SC_CARRY_IN  out  SC_COUNT  per-element carry input
SC_DATA_OUT  in  WORD_W*SC_COUNT  element counter values
SC_CARRY_OUT  in  SC_COUNT  element carry outputs
RSP_VALID  out  1  response beat valid
RSP_READY  in  1  response beat consumed when VALID&READY
RSP_DATA  out  WORD_W  counter word (GET/GETnINC), 0 for SET acks/errors
RSP_TAG  out  TAG_W  tag of originating request
RSP_LAST  out  1  final beat of response
RSP_CARRY  out  1  GETnINC wrapped the whole group (valid on every beat)
RSP_ERR  out  1  request rejected (group exceeds SC_COUNT)

Behaviour:
- Reset (async, nRST low): state IDLE; REQ_READY=0, SC_nEN all 1, SC_OP all 0, SC_DATA_IN=0, RSP_VALID/RSP_LAST/RSP_CARRY/RSP_ERR=0, RSP_DATA=0, RSP_TAG=0. REQ_READY rises on the first CLK edge after release. Reset mid-command discards the command; no element is enabled afterwards.
- All SC_* outputs except SC_CARRY_IN are registered. SC_CARRY_IN is combinational: SC_CARRY_IN[b+k] = SC_CARRY_OUT[b+k-1] for 0<k<=LEN while ISSUE drives group b, else 0.
- States: IDLE, WDATA, ISSUE, RESP.
- IDLE, READY=1: header accepted at edge T. REQ_INDEX+REQ_LEN >= SC_COUNT gives error response -> RESP (single beat, ERR=1, LAST=1, DATA=0, no element touched).
  - GET/GETnINC -> ISSUE.
  - SET/SET_LIMIT: header REQ_DATA is word 0. Element b is written in cycle T+1 (nEN[b]=0, OP[b]=op, DATA_IN=word). LEN=0 -> RESP; else -> WDATA.
- WDATA, READY=1: each accepted beat k writes element b+k in the following cycle. Bubbles allowed between beats; nEN stays high during bubbles. After beat LEN -> RESP with a single ack beat (DATA=0, LAST=1), valid the cycle after the last write.
- ISSUE (1 cycle, READY=0):
  - nEN low for b..b+LEN; OP[b]=requested op; OP[b+k>0]=GET so upper words advance only via carry.
  - At the edge, capture SC_DATA_OUT[b..b+LEN] (pre-increment values) into the response buffer.
  - RSP_CARRY = SC_CARRY_OUT[b+LEN] & (op==GETnINC).
  - -> RESP. RSP_VALID is first high at T+2 relative to the header.
- RESP, READY=0: emits LEN+1 beats, LS word first; RSP_LAST on the final beat. Fields stay stable while VALID & !READY. After the last handshake -> IDLE; REQ_READY=1 in the next cycle. No request overlap.
- GET never modifies elements. GETnINC on a group at all-limit values wraps every word to 0 and sets RSP_CARRY.

Test Plan:
- After reset, check all outputs at reset values. Then SET idx=2 len=1 words 0x0005,0x0000 -> elements 2,3 written on consecutive cycles; one ack beat TAG echoed, ERR=0.
- GETnINC idx=2 len=1 on {0xFFFF,0x0001} -> RSP beats 0xFFFF then 0x0001 (LAST); element 2=0x0000, element 3=0x0002; RSP_CARRY=0.
- SET_LIMIT idx=0 len=0 data 0x0003, SET 0x0003, GETnINC -> RSP 0x0003, RSP_CARRY=1, element 0 now 0.
- Request idx=7 len=1 (SC_COUNT=8) -> single beat ERR=1, LAST=1, DATA=0; all SC_nEN stay high throughout.
- RSP_READY held low 5 cycles during a 4-word GET -> beat 0 held stable; REQ_READY=0 until the final beat is consumed; SET data beats with 2-cycle bubbles -> no spurious nEN.
- Assert nRST during WDATA after beat 1 of a 4-word SET -> no further element writes; REQ_READY=1 one cycle after release.
